// File: rtl/croc_pkg.sv
// rtl/croc_pkg.sv - core-side interrupt vector constants shared by the IRQ router
package croc_pkg;

  localparam int unsigned CoreIrqWidth    = 32;
  localparam int unsigned CoreIrqIdWidth  = 5;
  localparam int unsigned CoreMtiIdx      = 7;
  localparam int unsigned CoreFastIrqBase = 16;

  typedef logic [CoreIrqIdWidth-1:0] irq_id_t;

  // Core interrupt id that an external channel is presented on.
  function automatic irq_id_t ext_irq_id(input int unsigned base, input int unsigned ch);
    return CoreIrqIdWidth'(base + ch);
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// rtl/irq_sync_edge.sv - per-line synchroniser with rising-edge detector
module irq_sync_edge #(
  parameter int unsigned SyncStages = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic s_o,
  output logic rise_o
);

  logic s_q;

  generate
    if (SyncStages == 0) begin : g_bypass
      assign s_o = d_i;
    end else begin : g_sync
      logic [SyncStages-1:0] stage_q;

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          stage_q <= '0;
        end else begin
          stage_q[0] <= d_i;
          for (int unsigned i = 1; i < SyncStages; i++) begin
            stage_q[i] <= stage_q[i-1];
          end
        end
      end

      assign s_o = stage_q[SyncStages-1];
    end
  endgenerate

  // Cleared in reset so a line held high through reset yields one rise afterwards.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s_q <= 1'b0;
    end else begin
      s_q <= s_o;
    end
  end

  assign rise_o = s_o & ~s_q;

endmodule

// File: rtl/core_irq_router.sv
// rtl/core_irq_router.sv - routes platform IRQ lines and the machine timer into the core irq vector
module core_irq_router
  import croc_pkg::*;
#(
  parameter int unsigned NumExtIrqs = 16,
  parameter int unsigned ExtIrqBase = 16,
  parameter int unsigned SyncStages = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NumExtIrqs-1:0]     irqs_i,
  input  logic                      timer_irq_i,
  input  logic [NumExtIrqs-1:0]     cfg_en_i,
  input  logic [NumExtIrqs-1:0]     cfg_edge_i,
  input  logic                      clr_valid_i,
  input  logic [3:0]                clr_idx_i,
  input  logic                      irq_ack_i,
  input  logic [CoreIrqIdWidth-1:0] irq_id_i,
  output logic [CoreIrqWidth-1:0]   irq_o,
  output logic [NumExtIrqs-1:0]     pending_o,
  output logic [NumExtIrqs-1:0]     missed_o,
  output logic                      any_irq_o
);

  generate
    if (NumExtIrqs < 1 || NumExtIrqs > 16) begin : g_bad_num
      $error("core_irq_router: NumExtIrqs must be in 1..16");
    end
    if (ExtIrqBase < CoreFastIrqBase || ExtIrqBase + NumExtIrqs > CoreIrqWidth) begin : g_bad_base
      $error("core_irq_router: ExtIrqBase must be >= 16 with ExtIrqBase+NumExtIrqs <= 32");
    end
  endgenerate

  logic [NumExtIrqs-1:0] s;
  logic [NumExtIrqs-1:0] rise;
  logic [NumExtIrqs-1:0] edge_mode;
  logic [NumExtIrqs-1:0] ack_hit;
  logic [NumExtIrqs-1:0] sw_hit;
  logic [NumExtIrqs-1:0] req;
  logic [NumExtIrqs-1:0] pend_q;
  logic [NumExtIrqs-1:0] missed_q;

  generate
    for (genvar c = 0; c < NumExtIrqs; c++) begin : g_ch
      irq_sync_edge #(
        .SyncStages(SyncStages)
      ) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (irqs_i[c]),
        .s_o   (s[c]),
        .rise_o(rise[c])
      );

      assign edge_mode[c] = cfg_en_i[c] & cfg_edge_i[c];
      assign ack_hit[c]   = irq_ack_i & (irq_id_i == ext_irq_id(ExtIrqBase, c));
      assign sw_hit[c]    = clr_valid_i & (clr_idx_i == 4'(c));
      assign req[c]       = cfg_edge_i[c] ? pend_q[c] : (cfg_en_i[c] & s[c]);
    end
  endgenerate

  // A rise beats a same-cycle clear; leaving edge mode wipes both latches.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q   <= '0;
      missed_q <= '0;
    end else begin
      pend_q   <= edge_mode & (rise | (pend_q & ~(ack_hit | sw_hit)));
      missed_q <= edge_mode & ~sw_hit & (missed_q | (rise & pend_q & ~ack_hit));
    end
  end

  always_comb begin
    irq_o = '0;
    if (!rst_i) begin
      irq_o[CoreMtiIdx] = timer_irq_i;
      for (int unsigned c = 0; c < NumExtIrqs; c++) begin
        irq_o[ExtIrqBase + c] = req[c];
      end
    end
  end

  assign pending_o = rst_i ? '0 : req;
  assign missed_o  = rst_i ? '0 : missed_q;
  assign any_irq_o = |irq_o;

endmodule

// File: tb/tb_core_irq_router.sv
// tb/tb_core_irq_router.sv - randomized self-checking bench for core_irq_router
module tb_core_irq_router;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] irqs;
  logic [15:0] cfg_en;
  logic [15:0] cfg_edge;
  logic        timer;
  logic        clr_valid;
  logic [3:0]  clr_idx;
  logic        ack;
  logic [4:0]  ack_id;

  logic [31:0] irq_a;
  logic [15:0] pend_a;
  logic [15:0] miss_a;
  logic        any_a;
  logic [31:0] irq_b;
  logic [3:0]  pend_b;
  logic [3:0]  miss_b;
  logic        any_b;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  core_irq_router #(.NumExtIrqs(16), .ExtIrqBase(16), .SyncStages(2)) u_dut_a (
    .clk_i      (clk),
    .rst_i      (rst),
    .irqs_i     (irqs),
    .timer_irq_i(timer),
    .cfg_en_i   (cfg_en),
    .cfg_edge_i (cfg_edge),
    .clr_valid_i(clr_valid),
    .clr_idx_i  (clr_idx),
    .irq_ack_i  (ack),
    .irq_id_i   (ack_id),
    .irq_o      (irq_a),
    .pending_o  (pend_a),
    .missed_o   (miss_a),
    .any_irq_o  (any_a)
  );

  core_irq_router #(.NumExtIrqs(4), .ExtIrqBase(28), .SyncStages(0)) u_dut_b (
    .clk_i      (clk),
    .rst_i      (rst),
    .irqs_i     (irqs[3:0]),
    .timer_irq_i(timer),
    .cfg_en_i   (cfg_en[3:0]),
    .cfg_edge_i (cfg_edge[3:0]),
    .clr_valid_i(clr_valid),
    .clr_idx_i  (clr_idx),
    .irq_ack_i  (ack),
    .irq_id_i   (ack_id),
    .irq_o      (irq_b),
    .pending_o  (pend_b),
    .missed_o   (miss_b),
    .any_irq_o  (any_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: d=0 is the 16ch/base16/2-stage DUT, d=1 the 4ch/base28/0-stage DUT.
  logic [15:0] hist0[2];
  logic [15:0] hist1[2];
  logic [15:0] last_s[2];
  logic [15:0] m_pend[2];
  logic [15:0] m_miss[2];

  function automatic int n_of(input int d);    return (d == 0) ? 16 : 4;  endfunction
  function automatic int base_of(input int d); return (d == 0) ? 16 : 28; endfunction
  function automatic logic [15:0] mask_of(input int d); return (d == 0) ? 16'hffff : 16'h000f; endfunction

  // Line level as seen after the synchroniser delay.
  function automatic logic [15:0] line_seen(input int d);
    return (d == 0) ? hist1[d] : (irqs & mask_of(d));
  endfunction

  function automatic logic [15:0] exp_pending(input int d);
    logic [15:0] v;
    logic [15:0] s;
    v = '0;
    s = line_seen(d);
    if (rst) return '0;
    for (int c = 0; c < n_of(d); c++)
      v[c] = cfg_edge[c] ? m_pend[d][c] : (cfg_en[c] & s[c]);
    return v;
  endfunction

  function automatic logic [31:0] exp_irq(input int d);
    if (rst) return '0;
    return ({16'h0, exp_pending(d)} << base_of(d)) | (32'(timer) << 7);
  endfunction

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        hist0[d] = '0; hist1[d] = '0; last_s[d] = '0; m_pend[d] = '0; m_miss[d] = '0;
      end else begin
        logic [15:0] s;
        s = line_seen(d);
        for (int c = 0; c < n_of(d); c++) begin
          bit rise, hit_ack, hit_sw;
          rise    = s[c] && !last_s[d][c];
          hit_ack = ack && (int'(ack_id) == base_of(d) + c);
          hit_sw  = clr_valid && (int'(clr_idx) == c);
          if (!(cfg_en[c] && cfg_edge[c])) begin
            m_pend[d][c] = 1'b0;
            m_miss[d][c] = 1'b0;
          end else begin
            if (rise) begin
              if (m_pend[d][c] && !hit_ack && !hit_sw) m_miss[d][c] = 1'b1;
              m_pend[d][c] = 1'b1;
            end else if (hit_ack || hit_sw) begin
              m_pend[d][c] = 1'b0;
            end
            if (hit_sw) m_miss[d][c] = 1'b0;
          end
        end
        hist1[d]  = hist0[d];
        hist0[d]  = irqs & mask_of(d);
        last_s[d] = s;
      end
    end
  endtask

  task automatic compare();
    logic [15:0] mb;
    mb = rst ? 16'h0 : m_miss[1];
    check("irq_a",     irq_a,          exp_irq(0));
    check("pending_a", 32'(pend_a),    32'(exp_pending(0)));
    check("missed_a",  32'(miss_a),    rst ? 32'h0 : 32'(m_miss[0]));
    check("any_a",     32'(any_a),     32'(exp_irq(0) != 0));
    check("irq_b",     irq_b,          exp_irq(1));
    check("pending_b", 32'(pend_b),    32'(exp_pending(1) & 16'h000f));
    check("missed_b",  32'(miss_b),    32'(mb & 16'h000f));
    check("any_b",     32'(any_b),     32'(exp_irq(1) != 0));
  endtask

  // Inputs are set just after a rising edge; outputs checked at the falling edge.
  task automatic cycle();
    @(negedge clk);
    compare();
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; irqs = '0; cfg_en = '0; cfg_edge = '0; timer = 1'b0;
    clr_valid = 1'b0; clr_idx = '0; ack = 1'b0; ack_id = '0;
    for (int d = 0; d < 2; d++) begin
      hist0[d] = '0; hist1[d] = '0; last_s[d] = '0; m_pend[d] = '0; m_miss[d] = '0;
    end
    @(posedge clk); #1;
    timer = 1'b1; irqs = 16'hffff;
    #2;
    check("reset_irq_zero", irq_a, 32'h0);
    cycle();
    cycle();
    timer = 1'b0; irqs = '0;
    rst = 1'b0;

    // ch3 edge: single-cycle pulse reaches irq_o[19] on the third cycle, then ack clears it.
    cfg_en = 16'h0008; cfg_edge = 16'h0008;
    irqs = 16'h0008;
    cycle();
    irqs = '0;
    cycle();
    #2;
    check("ch3_not_yet", 32'(irq_a[19]), 32'h0);
    cycle();
    #2;
    check("ch3_latency", 32'(irq_a[19]), 32'h1);
    cycle();
    cycle();
    ack = 1'b1; ack_id = 5'd19;
    cycle();
    ack = 1'b0;
    #2;
    check("ch3_acked", 32'(irq_a[19]), 32'h0);
    cycle();

    timer = 1'b1;
    #2;
    check("timer_passthru", 32'(irq_a[7]), 32'h1);
    cycle();
    timer = 1'b0;

    // Random phase with occasional reconfiguration and reset.
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 39) == 0) begin
        cfg_en   = 16'($urandom) | 16'($urandom);
        cfg_edge = 16'($urandom);
      end
      irqs      = irqs ^ (16'($urandom) & 16'($urandom));
      if ($urandom_range(0, 3) == 0) timer = ~timer;
      ack       = $urandom_range(0, 1) == 1;
      ack_id    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(16, 31));
      clr_valid = $urandom_range(0, 3) == 0;
      clr_idx   = 4'($urandom_range(0, 15));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
